// File: rtl/mux4_sel_pkg.sv
// Shared constants and state type for the 4-input MUX selector arbiter.
package mux4_sel_pkg;

    localparam int N_IN  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin pick: the first set bit of mask, searched upward from ptr
// with a wrap from 3 back to 0.
module rr_pick4
    import mux4_sel_pkg::*;
(
    input  logic [N_IN-1:0]  mask,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win,
    output logic             found
);

    logic [SEL_W-1:0] idx;
    logic             hit;

    // Walk the channels from ptr; the first set bit encountered wins.
    always_comb begin
        win   = '0;
        found = |mask;
        hit   = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_IN; i++) begin
            idx = ptr + SEL_W'(i);
            if (!hit && mask[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_select_ctrl.sv
// Round-robin arbiter driving the 2-bit selector of an 8-bit 4:1 data MUX.
// One grant is held until the consumer accepts it. On acceptance the next
// requester (excluding the channel just served) is picked in the same cycle,
// which allows back-to-back transfers.
module mux4_rr_select_ctrl
    import mux4_sel_pkg::*;
#(
    parameter logic [SEL_W-1:0] INIT_PTR = 2'd0,
    parameter int               CNT_W    = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [N_IN-1:0]  Req,
    input  logic             OutReady,
    output logic [SEL_W-1:0] Selector,
    output logic             OutValid,
    output logic [N_IN-1:0]  Ack,
    output logic [CNT_W-1:0] TxCount
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic             fire;
    logic [N_IN-1:0]  pick_mask;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_win;
    logic             pick_found;

    // Transfer handshake and the one-hot acknowledge to the winning source.
    always_comb begin
        fire = OutValid & OutReady;
        Ack  = fire ? (4'b0001 << Selector) : 4'b0000;
    end

    // Shared picker inputs. Ack is zero in IDLE, so masking with ~Ack is only
    // effective on the BUSY re-pick, where it excludes the channel just served.
    // The BUSY re-pick searches from Selector+1, which is the value Ptr takes
    // at the same edge.
    always_comb begin
        pick_mask = Req & ~Ack;
        pick_ptr  = (state == ST_BUSY) ? (Selector + 2'd1) : ptr;
    end

    rr_pick4 u_pick (
        .mask  (pick_mask),
        .ptr   (pick_ptr),
        .win   (pick_win),
        .found (pick_found)
    );

    // Arbiter state machine with registered selector and valid outputs.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state    <= ST_IDLE;
            Selector <= '0;
            OutValid <= 1'b0;
            ptr      <= INIT_PTR;
            TxCount  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        Selector <= pick_win;
                        OutValid <= 1'b1;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (fire) begin
                        ptr     <= Selector + 2'd1;
                        TxCount <= TxCount + CNT_W'(1);
                        if (pick_found) begin
                            Selector <= pick_win;
                        end else begin
                            OutValid <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    OutValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_select_ctrl.sv
// Scoreboard bench for mux4_rr_select_ctrl: the driver pushes the expected
// per-cycle outputs from a transaction-level model, and a monitor pops and
// compares them against both DUT instances (8-bit and 2-bit counters).
module tb_mux4_rr_select_ctrl;

    logic       Clk;
    logic       Reset_n;
    logic [3:0] Req;
    logic       OutReady;
    logic [1:0] Selector,  Selector2;
    logic       OutValid,  OutValid2;
    logic [3:0] Ack,       Ack2;
    logic [7:0] TxCount;
    logic [1:0] TxCount2;

    mux4_rr_select_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .OutReady(OutReady),
        .Selector(Selector), .OutValid(OutValid), .Ack(Ack), .TxCount(TxCount)
    );

    mux4_rr_select_ctrl #(.INIT_PTR(2'd0), .CNT_W(2)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .OutReady(OutReady),
        .Selector(Selector2), .OutValid(OutValid2), .Ack(Ack2), .TxCount(TxCount2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int       sel;
        bit       valid;
        bit [3:0] ack;
        int       cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model state: the granted channel, whether a grant is outstanding,
    // the channel searched first, and completed transfers.
    int       m_sel   = 0;
    bit       m_valid = 0;
    int       m_ptr   = 0;
    int       m_cnt   = 0;
    bit [3:0] last_ack = 0;

    function automatic int rr_search(input bit [3:0] mask, input int start);
        for (int k = 0; k < 4; k++)
            if (mask[(start + k) % 4]) return (start + k) % 4;
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    // One cycle: drive inputs, publish the expected outputs, advance the model.
    task automatic step(input bit rn, input bit [3:0] rq, input bit rdy, input bit chk);
        exp_t     e;
        int       w;
        bit [3:0] ack;
        @(negedge Clk);
        Reset_n  = rn;
        Req      = rq;
        OutReady = rdy;
        ack = (m_valid && rdy) ? 4'(1 << m_sel) : 4'b0000;
        e.sel = m_sel; e.valid = m_valid; e.ack = ack; e.cnt = m_cnt;
        if (chk) q.push_back(e);
        last_ack = ack;
        if (!rn) begin
            m_valid = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_valid) begin
            w = rr_search(rq, m_ptr);
            if (w >= 0) begin m_valid = 1; m_sel = w; end
        end else if (rdy) begin
            m_cnt++;
            m_ptr = (m_sel + 1) % 4;
            w = rr_search(rq & ~ack, m_ptr);
            if (w >= 0) m_sel = w;
            else m_valid = 0;
        end
    endtask

    // Monitor: compare every published expectation against both DUTs.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                check("OutValid",  int'(OutValid),  int'(e.valid));
                check("Ack",       int'(Ack),       int'(e.ack));
                check("TxCount",   int'(TxCount),   e.cnt % 256);
                check("TxCount2",  int'(TxCount2),  e.cnt % 4);
                check("OutValid2", int'(OutValid2), int'(e.valid));
                if (e.valid || !Reset_n) check("Selector", int'(Selector), e.sel);
            end
        end
    end

    initial begin
        bit [3:0] rq;
        bit       rdy;
        bit       rn;
        int       guard;
        Reset_n = 1'b0; Req = 4'b1111; OutReady = 1'b1;

        // Reset with all requests held
        step(0, 4'b1111, 1, 0);
        repeat (3) step(0, 4'b1111, 1, 1);

        // Single request on channel 2, then idle
        step(1, 4'b0100, 1, 1);
        step(1, 4'b0100, 1, 1);
        step(1, 4'b0000, 1, 1);
        step(1, 4'b0000, 1, 1);

        // All requesting: rotation every cycle, counter wraps on dut2
        step(0, 4'b0000, 1, 1);
        repeat (10) step(1, 4'b1111, 1, 1);
        step(1, 4'b0000, 1, 1);
        step(1, 4'b0000, 1, 1);

        // Stalled grant on channel 1 while channel 3 rises
        step(0, 4'b0000, 0, 1);
        step(1, 4'b0010, 0, 1);
        repeat (5) step(1, 4'b1010, 0, 1);
        step(1, 4'b1010, 1, 1);
        step(1, 4'b1000, 1, 1);
        step(1, 4'b0000, 1, 1);

        // Reset during a stalled transfer
        step(1, 4'b0001, 0, 1);
        step(1, 4'b0001, 0, 1);
        step(0, 4'b0001, 0, 1);
        step(1, 4'b0000, 0, 1);
        step(1, 4'b0000, 1, 1);

        // Randomized traffic obeying the hold-until-ack source rule
        rq = 4'b0000;
        for (int c = 0; c < 500; c++) begin
            rq &= ~last_ack;
            for (int i = 0; i < 4; i++)
                if (!rq[i] && ($urandom % 3 == 0)) rq[i] = 1'b1;
            rdy = ($urandom % 4) != 0;
            rn  = ($urandom % 80) != 0;
            if (m_valid && !rdy && ($urandom % 8 == 0)) rq[m_sel] = 1'b0;
            if (!rn) rq = 4'b0000;
            step(rn, rq, rdy, 1);
        end

        repeat (3) step(1, 4'b0000, 1, 1);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge Clk);
            guard++;
        end
        #4;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
